alu_muldiv_ctrl: RTL and testbench
==================================

ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00 MULTU, 01 DIVU, 1x reserved.
REQ-006 src_a  input  32  multiplicand / dividend.
REQ-007 src_b  input  32  multiplier / divisor.
REQ-008 busy  output  1  high in CALC and DONE.
REQ-009 done  output  1  one-cycle pulse, results valid.
REQ-010 hi  output  32  product[63:32] / remainder.
REQ-011 lo  output  32  product[31:0] / quotient.
REQ-012 div_by_zero  output  1  divide-by-zero flag, valid with done.
REQ-013 alu_sel  output  3  ALU select driven to the shared 32-bit ALU.
REQ-014 alu_a  output  32  ALU operand A.
REQ-015 alu_b  output  32  ALU operand B.
REQ-016 alu_result  input  32  combinational ALU sum.
REQ-017 alu_cout  input  1  ALU carry-out of MSB slice.

Function
REQ-018 States IDLE, CALC, DONE; 5-bit iteration counter cnt.
REQ-019 IDLE: start=1 with op 00/01 -> latch operands, cnt=0, go CALC; op 1x or start=0 -> stay IDLE, no outputs change.
REQ-020 MULTU load: hi=0, lo=src_b, mcand=src_a.
REQ-021 MULTU CALC cycle: alu_sel=010 (add), alu_a=hi, alu_b=lo[0]?mcand:0; then hi<={alu_cout,alu_result[31:1]}, lo<={alu_result[0],lo[31:1]}.
REQ-022 DIVU load: hi=0, lo=src_a, divisor=src_b.
REQ-023 DIVU CALC cycle: alu_sel=110 (sub), alu_a={hi[30:0],lo[31]}, alu_b=divisor; alu_cout=1 -> hi<=alu_result, lo<={lo[30:0],1}; else hi<=alu_a, lo<={lo[30:0],0}.
REQ-024 CALC runs exactly 32 cycles (cnt 0..31), then DONE.
REQ-025 DONE lasts one cycle: done=1, busy=1, then IDLE; done asserted on the 33rd cycle after the accepting edge.
REQ-026 start in CALC or DONE is ignored; not queued.
REQ-027 hi, lo, div_by_zero hold final values until the next accepted start.
REQ-028 Outside CALC: alu_sel=010, alu_a=0, alu_b=0.
REQ-029 DIVU by zero without fast path yields lo=0xFFFFFFFF, hi=src_a (natural restoring result).

Reset
REQ-030 rst=0 at any clock edge, including mid-CALC: state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0; in-flight operation discarded, no done produced.
REQ-031 rst has priority over start on the same edge.

Configuration
REQ-032 Macro ALU_MULDIV_DIVZERO_EN defined: DIVU with src_b=0 skips CALC, next cycle DONE with hi=src_a, lo=0xFFFFFFFF, div_by_zero=1 (done 1 cycle after accept).
REQ-033 Macro undefined: div_by_zero tied 0; divide by zero runs full 32 cycles per REQ-029.

Structure
REQ-034 Shared package alu_pkg holds ALU select constants (AND 000, OR 001, ADD 010, SUB 110, SLT 111), op encodings, state enum.
REQ-035 No sub-module; ALU is external and shared, counter inline.

Verification
REQ-036 MULTU 0x00000003 x 0x00000005 -> done 33 cycles after start, hi=0x00000000, lo=0x0000000F.
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 DIVU 100 / 7 -> lo=14, hi=2; DIVU 0xFFFFFFFF / 0xFFFFFFFE -> lo=1, hi=1.
REQ-039 DIVU 0x12345678 / 0 -> with macro: done 1 cycle after accept, div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF; without: done at 33 cycles, same hi/lo, div_by_zero=0.
REQ-040 start with op=10 -> stays IDLE, no done; start pulsed mid-CALC -> ignored, first result unaffected.
REQ-041 rst=0 at CALC cycle 10 of MULTU -> next cycle IDLE, hi=lo=0, busy=0, no done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide sequencer and the external ALU it drives.
package alu_pkg;

  // ALU select encodings understood by the shared 32-bit ALU
  localparam logic [2:0] AluSelAnd = 3'b000;
  localparam logic [2:0] AluSelOr  = 3'b001;
  localparam logic [2:0] AluSelAdd = 3'b010;
  localparam logic [2:0] AluSelSub = 3'b110;
  localparam logic [2:0] AluSelSlt = 3'b111;

  // Operation encodings; op[1] set means reserved
  localparam logic [1:0] OpMultu = 2'b00;
  localparam logic [1:0] OpDivu  = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/alu_muldiv_ctrl.sv
// Iterative unsigned multiply/divide sequencer that borrows an external shared ALU.
// One result bit per cycle over 32 CALC cycles.
// Optional macro ALU_MULDIV_DIVZERO_EN: divide by zero skips CALC and flags div_by_zero.
module alu_muldiv_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand or divisor
  logic             is_div_q, is_div_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] shift_a;

  // Partial remainder shifted left with the next dividend bit
  assign shift_a = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  // Next-state, datapath updates and ALU drive
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    alu_sel  = AluSelAdd;
    alu_a    = '0;
    alu_b    = '0;
    unique case (state_q)
      StIdle: begin
        if (start && !op[1]) begin
          hi_d     = '0;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          is_div_d = (op == OpDivu);
          state_d  = StCalc;
          if (op == OpDivu) begin
            lo_d   = src_a;
            opnd_d = src_b;
`ifdef ALU_MULDIV_DIVZERO_EN
            if (src_b == '0) begin
              hi_d    = src_a;
              lo_d    = '1;
              dbz_d   = 1'b1;
              state_d = StDone;
            end
`endif
          end else begin
            lo_d   = src_b;
            opnd_d = src_a;
          end
        end
      end
      StCalc: begin
        if (is_div_q) begin
          // Restoring division: keep the difference only when no borrow
          alu_sel = AluSelSub;
          alu_a   = shift_a;
          alu_b   = opnd_q;
          if (alu_cout) begin
            hi_d = alu_result;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = shift_a;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Shift-add multiply: the 64-bit {hi,lo} shifts right each step
          alu_sel = AluSelAdd;
          alu_a   = hi_q;
          alu_b   = lo_q[0] ? opnd_q : '0;
          hi_d    = {alu_cout, alu_result[WIDTH-1:1]};
          lo_d    = {alu_result[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef ALU_MULDIV_DIVZERO_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Scoreboard bench for alu_muldiv_ctrl with a behavioural model of the shared ALU.
module tb_alu_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, div_by_zero, alu_cout;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_sel;
  logic [32:0] alu_sum;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .alu_sel     (alu_sel),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External ALU model
  always_comb begin
    alu_sum = '0;
    case (alu_sel)
      3'b000:  alu_sum = {1'b0, alu_a & alu_b};
      3'b001:  alu_sum = {1'b0, alu_a | alu_b};
      3'b010:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      3'b111:  alu_sum = {32'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_sum = '0;
    endcase
  end
  assign alu_result = alu_sum[31:0];
  assign alu_cout   = alu_sum[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents done
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("hi", {32'd0, hi}, {32'd0, e.hi});
        check("lo", {32'd0, lo}, {32'd0, e.lo});
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
        check("latency", 64'(cyc - e.acc), 64'(e.lat));
        check("busy_with_done", {63'd0, busy}, 64'd1);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    e.lat = lat;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while ((sb.size() != 0 || busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", {63'd0, (i >= budget)}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check("idle_alu_sel", {61'd0, alu_sel}, 64'd2);
    check("idle_alu_a", {32'd0, alu_a}, 64'd0);
    check("idle_alu_b", {32'd0, alu_b}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0000_000F, 1'b0, 32);
    @(negedge clk);
    check("calc_alu_sel_mul", {61'd0, alu_sel}, 64'd2);
    drain(100);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32);
    drain(100);
    issue(2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 32);
    drain(100);
    issue(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
    @(negedge clk);
    check("calc_alu_sel_div", {61'd0, alu_sel}, 64'd6);
    check("calc_alu_b_div", {32'd0, alu_b}, 64'd7);
    drain(100);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'h1, 1'b0, 32);
    drain(100);
`ifdef ALU_MULDIV_DIVZERO_EN
    issue(2'b01, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 0);
`else
    issue(2'b01, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32);
`endif
    drain(100);

    // start during CALC must be ignored
    issue(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, 1'b0, 32);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    src_a = 32'd9;
    src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    drain(100);

    // Reserved op: stay idle, outputs unchanged
    start = 1'b1;
    op    = 2'b10;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'h5;
    @(negedge clk);
    start = 1'b0;
    check("reserved_busy", {63'd0, busy}, 64'd0);
    check("reserved_hi", {32'd0, hi}, 64'd1);
    check("reserved_lo", {32'd0, lo}, 64'd0);
    repeat (40) @(negedge clk);

    // Reset in the middle of a multiply
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'hFFFF_FFFF;
    src_b = 32'h7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midcalc_busy", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle", {63'd0, busy}, 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
